exp_adder_sched: RTL and testbench
==================================

Name: exp_adder_sched

Overview:
- Two-requester scheduler that owns one shared 8-bit exponent adder (sum = a + b + cin, 8-bit sum only, no carry-out port) in the FP multiplier pipeline.
- Arbitrates round-robin between two exponent-pair requesters.
- Sequences the adder through two passes, ea+eb then subtract BIAS, and returns a biased product exponent with overflow/underflow flags over a valid/ready handshake.
- The adder is instantiated beside this block; this block drives its operands and reads its sum.

Parameters:
BIAS, 127, exponent bias subtracted in pass 2 (8-bit value).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 pair accepted this cycle
req0_ea  in  8  requester 0 exponent A (biased)
req0_eb  in  8  requester 0 exponent B (biased)
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 pair accepted this cycle
req1_ea  in  8  requester 1 exponent A
req1_eb  in  8  requester 1 exponent B
add_a  out  8  shared adder operand A
add_b  out  8  shared adder operand B
add_cin  out  1  shared adder carry-in
add_sum  in  8  shared adder sum (combinational from add_a/add_b/add_cin)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_exp  out  8  result exponent
out_ovf  out  1  overflow (result >= 255)
out_unf  out  1  underflow (result <= 0)
out_id  out  1  requester index that owns the result

Behaviour:
- Reset: FSM=IDLE, out_valid=0, out_exp=0, out_ovf=0, out_unf=0, out_id=0, rr pointer=0 (requester 0 has priority first), req*_ready=0, add_a/add_b/add_cin=0.
- States:
  - IDLE: wait for a request.
  - P1: add_a=opA, add_b=opB, add_cin=0.
  - P2: add_a=s1, add_b=~BIAS[7:0], add_cin=1.
  - DONE: result held.
- Adder operands are registered-state driven. In IDLE and DONE they are 0/0/0.
- IDLE: if any reqN_valid, grant one and assert reqN_ready combinationally in that cycle.
  - Latch ea, eb and id; go to P1.
  - Only one ready is high per cycle. Ready is never high outside IDLE.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last. The rr pointer is updated on every grant.
- P1:
  - Register s1=add_sum.
  - Register c1 = (a7&b7) | ((a7^b7) & ~sum7), computed from add_a/add_b/add_sum bit 7.
  - Go to P2.
- P2:
  - Register s2=add_sum and c2 with the same formula; c2=1 means s1 >= BIAS.
  - Compute the result and load the out_* registers. out_valid=1 next cycle; go to DONE.
- Result rules (true value E = 256*c1 + s1 - BIAS):
  - c1=0, c2=0: unf=1, exp=0x00.
  - c1=1, c2=1: ovf=1, exp=0xFF.
  - Otherwise E=s2:
    - s2==0x00 → unf=1, exp=0x00.
    - s2==0xFF → ovf=1, exp=0xFF.
    - else exp=s2, flags 0.
  - ovf and unf are never both 1.
- DONE:
  - out_* stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid=0 next cycle; go to IDLE.
  - No new grant in the handshake cycle; earliest next grant is the following cycle.
- Latency: accept in cycle T, out_valid=1 in cycle T+3. Throughput is one result per 4 cycles minimum.
- Requester inputs are sampled only in the grant cycle. Later changes to reqN_ea/eb do not affect the in-flight operation.
- Reset asserted in any state: the next cycle is the reset state. The in-flight operation and any held result are discarded, and no ready is asserted in the reset cycle.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset, then req0 ea=130, eb=140 → req0_ready pulses 1 cycle; 3 cycles later out_exp=0x8F, ovf=0, unf=0, out_id=0. Check that in P1 add_a=0x82/add_b=0x8C/add_cin=0, and in P2 add_a=0x0E/add_b=0x80/add_cin=1.
- Boundaries:
  - 190+191 → 0xFE, no flags.
  - 191+191 → 0xFF, ovf=1.
  - 200+200 → 0xFF, ovf=1.
  - 60+67 → 0x00, unf=1.
  - 50+60 → 0x00, unf=1.
  - 127+128 → 0x80, no flags.
- req0 and req1 both held valid for 6 operations with out_ready=1 → grants alternate 0,1,0,1,0,1; out_id matches; each requester's values are correct.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs stable, no reqN_ready while req1_valid=1. Raise out_ready → out_valid drops next cycle, and req1 is granted the cycle after.
- Change req0_ea/eb after grant → result reflects the latched values.
- Assert rst in P2 → next cycle out_valid=0, state IDLE, rr pointer=0. With both requesters valid after reset, req0 is granted first.

Source files
------------

// File: rtl/exp_adder_sched.sv
// Round-robin scheduler for a shared 8-bit exponent adder: computes ea+eb-BIAS
// in two adder passes and returns a saturated biased exponent with ovf/unf flags.
module exp_adder_sched #(
  parameter logic [7:0] BIAS = 8'd127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_ea,
  input  logic [7:0] req0_eb,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_ea,
  input  logic [7:0] req1_eb,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_exp,
  output logic       out_ovf,
  output logic       out_unf,
  output logic       out_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_P1, ST_P2, ST_DONE} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_ea, r_eb, r_s1;
  logic       r_c1, r_id, r_rr;
  logic       r_out_valid, r_out_ovf, r_out_unf, r_out_id;
  logic [7:0] r_out_exp;
  logic       w_gnt0, w_gnt1, w_carry, w_ovf, w_unf;
  logic [7:0] w_exp;

  // r_rr names the requester that wins a tie
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == ST_IDLE && !rst) begin
      if (req0_valid && (!req1_valid || !r_rr)) w_gnt0 = 1'b1;
      else if (req1_valid)                      w_gnt1 = 1'b1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (r_state)
      ST_P1: begin
        add_a = r_ea;
        add_b = r_eb;
      end
      ST_P2: begin
        add_a   = r_s1;
        add_b   = ~BIAS;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_carry = (add_a[7] & add_b[7]) | ((add_a[7] ^ add_b[7]) & ~add_sum[7]);

  // Pass-2 sum and carry feed the output registers directly instead of
  // passing through s2/c2 registers; out_valid timing is unchanged.
  always_comb begin
    w_exp = add_sum;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (!r_c1 && !w_carry) begin
      w_exp = '0;
      w_unf = 1'b1;
    end else if (r_c1 && w_carry) begin
      w_exp = '1;
      w_ovf = 1'b1;
    end else if (add_sum == 8'h00) begin
      w_unf = 1'b1;
    end else if (add_sum == 8'hFF) begin
      w_ovf = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt0 || w_gnt1) w_next = ST_P1;
      ST_P1:   w_next = ST_P2;
      ST_P2:   w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ea        <= '0;
      r_eb        <= '0;
      r_s1        <= '0;
      r_c1        <= 1'b0;
      r_id        <= 1'b0;
      r_rr        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_exp   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_unf   <= 1'b0;
      r_out_id    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt0 || w_gnt1) begin
        r_ea <= w_gnt1 ? req1_ea : req0_ea;
        r_eb <= w_gnt1 ? req1_eb : req0_eb;
        r_id <= w_gnt1;
        r_rr <= w_gnt0;
      end
      if (r_state == ST_P1) begin
        r_s1 <= add_sum;
        r_c1 <= w_carry;
      end
      if (r_state == ST_P2) begin
        r_out_valid <= 1'b1;
        r_out_exp   <= w_exp;
        r_out_ovf   <= w_ovf;
        r_out_unf   <= w_unf;
        r_out_id    <= r_id;
      end
      if (r_state == ST_DONE && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_exp   = r_out_exp;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_exp_adder_sched.sv
// Self-checking bench for exp_adder_sched: boundary table, random operations against
// an arithmetic model, round-robin, backpressure and mid-operation reset sequences.
module tb_exp_adder_sched;

  localparam int BIAS = 127;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_ea, req0_eb, req1_ea, req1_eb;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin;
  logic       out_valid, out_ready;
  logic [7:0] out_exp;
  logic       out_ovf, out_unf, out_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b + {7'd0, add_cin};

  exp_adder_sched #(.BIAS(8'd127)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ea(req0_ea), .req0_eb(req0_eb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ea(req1_ea), .req1_eb(req1_eb),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_ovf(out_ovf), .out_unf(out_unf), .out_id(out_id)
  );

  typedef struct {
    int ea;
    int eb;
    int e;
    int o;
    int u;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // True exponent ea+eb-BIAS, saturated into the 1..254 normal range
  function automatic void model(input int ea, input int eb, output int e, output int o, output int u);
    int t;
    t = ea + eb - BIAS;
    o = 0;
    u = 0;
    if (t >= 255)    begin e = 255; o = 1; end
    else if (t <= 0) begin e = 0;   u = 1; end
    else             e = t;
  endfunction

  task automatic set_req(input int id, input logic v, input int ea, input int eb);
    if (id == 0) begin
      req0_valid = v; req0_ea = 8'(ea); req0_eb = 8'(eb);
    end else begin
      req1_valid = v; req1_ea = 8'(ea); req1_eb = 8'(eb);
    end
  endtask

  task automatic wait_grant(output int gid);
    gid = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) gid = 2;
      else if (req0_ready)          gid = 0;
      else if (req1_ready)          gid = 1;
      if (gid >= 0) break;
    end
    if (gid < 0) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_out();
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (seen == 0) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic chk_result(input string tag, input int id, input int ea, input int eb);
    int e, o, u;
    model(ea, eb, e, o, u);
    chk({tag, "_exp"}, int'(out_exp), e);
    chk({tag, "_ovf"}, int'(out_ovf), o);
    chk({tag, "_unf"}, int'(out_unf), u);
    chk({tag, "_id"},  int'(out_id),  id);
  endtask

  // One isolated operation with out_ready=1; operands are scrambled after the grant
  task automatic do_single(input int id, input int ea, input int eb);
    int g;
    out_ready = 1'b1;
    set_req(id, 1'b1, ea, eb);
    wait_grant(g);
    chk("grant_id", g, id);
    @(posedge clk); #1;
    set_req(id, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
    @(negedge clk);
    chk("p1_ready", int'(req0_ready | req1_ready), 0);
    chk("p1_add_a", int'(add_a), ea);
    chk("p1_add_b", int'(add_b), eb);
    chk("p1_cin",   int'(add_cin), 0);
    @(negedge clk);
    chk("p2_add_a", int'(add_a), (ea + eb) % 256);
    chk("p2_add_b", int'(add_b), 255 - BIAS);
    chk("p2_cin",   int'(add_cin), 1);
    chk("p2_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat3_valid", int'(out_valid), 1);
    chk_result("res", id, ea, eb);
    @(negedge clk);
    chk("hs_valid_drop", int'(out_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[7];
    int g, e0, o0, u0, hold_exp, hold_ovf, hold_unf, hold_id;
    int va[2][2];

    tbl[0] = '{130, 140, 8'h8F, 0, 0};
    tbl[1] = '{190, 191, 8'hFE, 0, 0};
    tbl[2] = '{191, 191, 8'hFF, 1, 0};
    tbl[3] = '{200, 200, 8'hFF, 1, 0};
    tbl[4] = '{60,  67,  8'h00, 0, 1};
    tbl[5] = '{50,  60,  8'h00, 0, 1};
    tbl[6] = '{127, 128, 8'h80, 0, 0};

    rst = 1'b1;
    out_ready = 1'b0;
    set_req(0, 1'b1, 1, 2);
    set_req(1, 1'b1, 3, 4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready",  int'(req0_ready | req1_ready), 0);
    chk("rst_valid",  int'(out_valid), 0);
    chk("rst_exp",    int'(out_exp), 0);
    chk("rst_flags",  int'({out_ovf, out_unf, out_id}), 0);
    chk("rst_adder",  int'({add_a, add_b, add_cin}), 0);
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Boundary table: the stored expectations must also agree with the model
    for (int i = 0; i < 7; i++) begin
      model(tbl[i].ea, tbl[i].eb, e0, o0, u0);
      if (e0 != tbl[i].e || o0 != tbl[i].o || u0 != tbl[i].u)
        $display("note: table row %0d disagrees with model", i);
      do_single(0, tbl[i].ea, tbl[i].eb);
      chk("tbl_exp", int'(out_exp), tbl[i].e);
      chk("tbl_ovf", int'(out_ovf), tbl[i].o);
      chk("tbl_unf", int'(out_unf), tbl[i].u);
    end

    for (int i = 0; i < 30; i++)
      do_single(int'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));

    // Round-robin from a fresh reset: both requesters held valid
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      va[r][0] = $urandom_range(0, 255);
      va[r][1] = $urandom_range(0, 255);
      set_req(r, 1'b1, va[r][0], va[r][1]);
    end
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      chk("rr_grant", g, k % 2);
      if (g != 0 && g != 1) g = k % 2;
      e0 = va[g][0];
      o0 = va[g][1];
      @(posedge clk); #1;
      va[g][0] = $urandom_range(0, 255);
      va[g][1] = $urandom_range(0, 255);
      set_req(g, 1'b1, va[g][0], va[g][1]);
      wait_out();
      chk_result("rr", g, e0, o0);
      if (k == 5) begin
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
      end
    end
    @(negedge clk);
    chk("rr_end_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // Backpressure: hold result for 5 cycles while req1 waits
    out_ready = 1'b0;
    set_req(0, 1'b1, 150, 100);
    wait_grant(g);
    chk("bp_grant0", g, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b1, 140, 10);
    wait_out();
    chk_result("bp0", 0, 150, 100);
    hold_exp = int'(out_exp); hold_ovf = int'(out_ovf);
    hold_unf = int'(out_unf); hold_id = int'(out_id);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_out", int'({out_exp, out_ovf, out_unf, out_id}),
          (hold_exp << 3) | (hold_ovf << 2) | (hold_unf << 1) | hold_id);
      chk("bp_no_ready", int'(req0_ready | req1_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop_valid", int'(out_valid), 0);
    chk("bp_req1_grant", int'(req1_ready), 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 0, 0);
    wait_out();
    chk_result("bp1", 1, 140, 10);
    @(posedge clk); #1;

    // Reset while in pass 2: result discarded, req0 wins after reset
    set_req(0, 1'b1, 200, 50);
    wait_grant(g);
    chk("rp_grant", g, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b1, 100, 100);
    set_req(1, 1'b1, 90, 90);
    @(negedge clk);
    chk("rp_in_p2", int'(add_cin), 1);
    chk("rp_no_ready", int'(req0_ready | req1_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rp_valid", int'(out_valid), 0);
    chk("rp_adder_idle", int'({add_a, add_b, add_cin}), 0);
    chk("rp_req0_first", int'({req0_ready, req1_ready}), 2);
    @(posedge clk); #1;
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    wait_out();
    chk_result("rp", 0, 100, 100);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
